// File: rtl/seg_display_mux.sv
// seg_display_mux
//   Time-multiplexes two hex digits onto one shared, active-low seven-segment bus.
//   Sequence: DIG0_ON -> BLANK0 -> DIG1_ON -> BLANK1 -> DIG0_ON.
//   The blank states keep both digits dark between digits, which stops ghosting.
//   'frame' pulses for one cycle each time DIG0_ON is entered.
//   Optional feature: define SEG_LZB_EN for leading-zero blanking on digit 1.
//   Timing does not change when SEG_LZB_EN is defined.
module seg_display_mux #(
    parameter int DIG_CYCLES   = 12000,  // cycles each digit is lit, >= 1
    parameter int BLANK_CYCLES = 600     // dark cycles between digits, 0 = no blanking
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] digit0,
    input  logic [3:0] digit1,
    output logic [6:0] seg,
    output logic [1:0] an,
    output logic       frame
);

    localparam int MAX_CYCLES   = (DIG_CYCLES > BLANK_CYCLES) ? DIG_CYCLES : BLANK_CYCLES;
    localparam int CW           = $clog2(MAX_CYCLES + 1);
    // With no blanking, a blank state can only be reached by reset.
    // That state then lasts a single cycle.
    localparam int BLANK_LAST_I = (BLANK_CYCLES == 0) ? 0 : BLANK_CYCLES - 1;

    localparam logic [CW-1:0] DIG_LAST   = CW'(DIG_CYCLES - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_LAST_I);

    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [1:0] AN_OFF  = 2'b11;

    typedef enum logic [1:0] {
        DIG0_ON = 2'd0,
        BLANK0  = 2'd1,
        DIG1_ON = 2'd2,
        BLANK1  = 2'd3
    } state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic          last;

    logic [6:0]    seg_nx;
    logic [1:0]    an_nx;
    logic          frame_nx;

    // Active-low hex decode, bit order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'h0:    s = 7'h40;
            4'h1:    s = 7'h79;
            4'h2:    s = 7'h24;
            4'h3:    s = 7'h30;
            4'h4:    s = 7'h19;
            4'h5:    s = 7'h12;
            4'h6:    s = 7'h02;
            4'h7:    s = 7'h78;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h10;
            4'hA:    s = 7'h08;
            4'hB:    s = 7'h03;
            4'hC:    s = 7'h46;
            4'hD:    s = 7'h21;
            4'hE:    s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // State and phase-counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= BLANK1;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // Next state: a state advances on the last cycle of its dwell.
    // The blank states are bypassed when there is no blanking.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt + 1'b1;
        if (state == DIG0_ON || state == DIG1_ON)
            last = (cnt == DIG_LAST);
        else
            last = (cnt == BLANK_LAST);
        if (last) begin
            cnt_nx = '0;
            case (state)
                DIG0_ON: state_nx = (BLANK_CYCLES == 0) ? DIG1_ON : BLANK0;
                BLANK0:  state_nx = DIG1_ON;
                DIG1_ON: state_nx = (BLANK_CYCLES == 0) ? DIG0_ON : BLANK1;
                default: state_nx = DIG0_ON;
            endcase
        end
    end

    // Output values for the next cycle.
    // A digit is sampled only on the edge that enters its DIG state.
    // Between state changes the outputs hold, and frame is a one-cycle pulse.
    always_comb begin
        seg_nx   = seg;
        an_nx    = an;
        frame_nx = 1'b0;
        if (last) begin
            case (state_nx)
                DIG0_ON: begin
                    seg_nx   = decode(digit0);
                    an_nx    = 2'b10;
                    frame_nx = 1'b1;
                end
                DIG1_ON: begin
`ifdef SEG_LZB_EN
                    // Leading zero on the left digit: keep the digit dark for this phase.
                    if (digit1 == 4'h0) begin
                        seg_nx = SEG_OFF;
                        an_nx  = AN_OFF;
                    end else begin
                        seg_nx = decode(digit1);
                        an_nx  = 2'b01;
                    end
`else
                    seg_nx = decode(digit1);
                    an_nx  = 2'b01;
`endif
                end
                default: begin
                    seg_nx = SEG_OFF;
                    an_nx  = AN_OFF;
                end
            endcase
        end
    end

    // Output register: outputs update on the same edge as the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            seg   <= SEG_OFF;
            an    <= AN_OFF;
            frame <= 1'b0;
        end else begin
            seg   <= seg_nx;
            an    <= an_nx;
            frame <= frame_nx;
        end
    end

endmodule
